carry_bypass_adder_pipe: RTL and testbench

CARRY_BYPASS_ADDER_PIPE -- requirements
Module: carry_bypass_adder_pipe

---
 rtl/cba_pkg.sv | 29 ++
 rtl/cba_block.sv | 42 ++++
 rtl/carry_bypass_adder_pipe.sv | 156 +++++++++++++++
 tb/tb_carry_bypass_adder_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cba_pkg.sv
// Shared definitions for the pipelined carry-bypass adder.
//   CBA_CNT_W    width of the bypass statistics counter
//   CBA_MAX_W    widest operand the stage payload can carry
//   cba_stage_t  per-stage payload: operands, partial sum, carry
//   cba_sat_add  saturating add used by the bypass counter
package cba_pkg;

  localparam int CBA_CNT_W = 16;
  localparam int CBA_MAX_W = 128;

  // Operands travel down the pipe whole; each stage only consumes its own
  // slice, and synthesis drops the bits that no later stage reads.
  typedef struct packed {
    logic [CBA_MAX_W-1:0] a;
    logic [CBA_MAX_W-1:0] b;
    logic [CBA_MAX_W-1:0] sum;
    logic                 carry;
  } cba_stage_t;

  function automatic logic [CBA_CNT_W-1:0] cba_sat_add(
    input logic [CBA_CNT_W-1:0] acc,
    input logic [CBA_CNT_W-1:0] inc
  );
    logic [CBA_CNT_W:0] full;
    full = {1'b0, acc} + {1'b0, inc};
    return full[CBA_CNT_W] ? {CBA_CNT_W{1'b1}} : full[CBA_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cba_block.sv
// One combinational carry-bypass block of BLK bits.
// Ports:
//   a, b  BLK-bit addend slices
//   cin   carry into the block
//   sum   BLK-bit sum slice
//   cout  carry out: cin when the whole block propagates, else ripple carry
//   p     group propagate (AND of a^b over the block)
module cba_block
  import cba_pkg::*;
#(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           p
);

  logic [BLK-1:0] pv;
  logic [BLK-1:0] gv;
  logic [BLK:0]   rc;

  assign pv = a ^ b;
  assign gv = a & b;

  always_comb begin
    rc    = '0;
    rc[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      rc[i+1] = gv[i] | (pv[i] & rc[i]);
    end
  end

  assign sum  = pv ^ rc[BLK-1:0];
  assign p    = &pv;
  // When every bit propagates the ripple carry equals cin anyway; taking cin
  // directly is what shortens the critical path.
  assign cout = p ? cin : rc[BLK];

endmodule

// File: rtl/carry_bypass_adder_pipe.sv
// Pipelined carry-bypass adder with valid/ready handshakes on both sides.
// Computes {cout,sum} = a + b + cin in L = WIDTH/(BLK*BPS) stages; stage k
// resolves bypass blocks k*BPS .. k*BPS+BPS-1. Stalls collapse bubbles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake; a, b, cin operands
//   out_valid/out_ready   result handshake; sum, cout result
//   stat_clr, bypass_cnt  bypass statistics (only with CBA_BYPASS_STATS_EN)
// Build option: define CBA_BYPASS_STATS_EN to add the saturating counter of
// bypassed blocks per accepted beat.
module carry_bypass_adder_pipe
  import cba_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout
`ifdef CBA_BYPASS_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [CBA_CNT_W-1:0] bypass_cnt
`endif
);

  localparam int SPAN = BLK * BPS;
  localparam int L    = WIDTH / SPAN;
  localparam int NBLK = WIDTH / BLK;

  if ((WIDTH % SPAN) != 0 || WIDTH > CBA_MAX_W) begin : g_bad_cfg
    $error("carry_bypass_adder_pipe: WIDTH must be a multiple of BLK*BPS and fit cba_stage_t");
  end

  cba_stage_t      stage_q [L];
  logic            vld_q   [L];
  logic [L-1:0]    adv;
  logic [NBLK-1:0] blk_p;

  // A stage may take new contents when it is empty or its contents move on
  // in the same cycle; evaluated from the output end backwards.
  always_comb begin
    adv      = '0;
    adv[L-1] = !vld_q[L-1] || out_ready;
    for (int k = L - 2; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end
  end

  assign in_ready = rst_n && adv[0];

  for (genvar k = 0; k < L; k++) begin : g_stage
    cba_stage_t      src;
    cba_stage_t      stage_d;
    logic            up_vld;
    logic [BPS:0]    c;
    logic [SPAN-1:0] s;

    if (k == 0) begin : g_first
      always_comb begin
        src              = '0;
        src.a[WIDTH-1:0] = a;
        src.b[WIDTH-1:0] = b;
        src.carry        = cin;
      end
      assign up_vld = in_valid;
    end else begin : g_next
      assign src    = stage_q[k-1];
      assign up_vld = vld_q[k-1];
    end

    assign c[0] = src.carry;

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      localparam int LSB = (k * BPS + j) * BLK;
      cba_block #(.BLK(BLK)) u_blk (
        .a    (src.a[LSB +: BLK]),
        .b    (src.b[LSB +: BLK]),
        .cin  (c[j]),
        .sum  (s[j*BLK +: BLK]),
        .cout (c[j+1]),
        .p    (blk_p[k*BPS + j])
      );
    end

    always_comb begin
      stage_d                    = src;
      stage_d.sum[k*SPAN +: SPAN] = s;
      stage_d.carry              = c[BPS];
    end

    // Payload is only loaded with a real beat, so an empty slot or a
    // stalled output never sees its data change.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[k]   <= 1'b0;
        stage_q[k] <= '0;
      end else if (adv[k]) begin
        vld_q[k] <= up_vld;
        if (up_vld) begin
          stage_q[k] <= stage_d;
        end
      end
    end
  end

  assign out_valid = vld_q[L-1];
  assign sum       = stage_q[L-1].sum[WIDTH-1:0];
  assign cout      = stage_q[L-1].carry;

`ifdef CBA_BYPASS_STATS_EN
  logic [CBA_CNT_W-1:0] bypass_cnt_q;
  logic [CBA_CNT_W-1:0] in_p_cnt;

  // Counted from the raw operands at acceptance so the count never waits on
  // the pipe draining.
  always_comb begin
    in_p_cnt = '0;
    for (int g = 0; g < NBLK; g++) begin
      in_p_cnt = in_p_cnt + CBA_CNT_W'(&(a[g*BLK +: BLK] ^ b[g*BLK +: BLK]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bypass_cnt_q <= '0;
    end else if (stat_clr) begin
      bypass_cnt_q <= '0;
    end else if (in_valid && in_ready) begin
      bypass_cnt_q <= cba_sat_add(bypass_cnt_q, in_p_cnt);
    end
  end

  assign bypass_cnt = bypass_cnt_q;
`endif

  // Block propagates feed only the bypass muxes; consumed operand slices of
  // later stages are dead by construction.
  logic unused_sink;
  always_comb begin
    unused_sink = ^blk_p;
    for (int k = 0; k < L; k++) begin
      unused_sink = unused_sink ^ (^stage_q[k]);
    end
  end

endmodule

// File: tb/tb_carry_bypass_adder_pipe.sv
module tb_carry_bypass_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        cin_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_s;
  logic        cout_s;
`ifdef CBA_BYPASS_STATS_EN
  logic        stat_clr;
  logic [15:0] bypass_cnt;
`endif

  carry_bypass_adder_pipe #(.WIDTH(16), .BLK(4), .BPS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .cin       (cin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum_s),
    .cout      (cout_s)
`ifdef CBA_BYPASS_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .bypass_cnt(bypass_cnt)
`endif
  );

  typedef struct {
    logic [16:0] val;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  bit   or_rand = 0;
  bit   or_fix = 1;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1;
    forever begin
      @(negedge clk);
      out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_fix;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic int nbyp(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    int n;
    d = x ^ y;
    n = 0;
    for (int g = 0; g < 4; g++) if (d[g*4 +: 4] == 4'hF) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h expected nothing", {cout_s, sum_s});
        end else begin
          e = sb.pop_front();
          if ({cout_s, sum_s} !== e.val) begin
            errors++;
            $display("FAIL result: got %h expected %h", {cout_s, sum_s}, e.val);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.acc != 2) begin
              errors++;
              $display("FAIL latency: got %0d expected 2", cyc - e.acc);
            end
          end
        end
      end
    end
  end

  // Expected value is hand-computed for directed beats, golden sum for random.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic [16:0] ev, input bit lat, input bit clr);
    int   guard;
    exp_t e;
    @(negedge clk);
    in_valid = 1;
    a_s = ta;
    b_s = tb;
    cin_s = tc;
`ifdef CBA_BYPASS_STATS_EN
    stat_clr = clr;
`endif
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end else begin
      e.val = ev;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
      if (clr) exp_cnt = 0;
      else exp_cnt = (exp_cnt + nbyp(ta, tb) > 65535) ? 65535 : exp_cnt + nbyp(ta, tb);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
`ifdef CBA_BYPASS_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      guard++;
      @(negedge clk);
      #3;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    rst_n = 0;
    in_valid = 0;
    a_s = 0;
    b_s = 0;
    cin_s = 0;
`ifdef CBA_BYPASS_STATS_EN
    stat_clr = 0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_sum", 32'({cout_s, sum_s}), 32'd0);
`ifdef CBA_BYPASS_STATS_EN
    chk("rel_cnt", 32'(bypass_cnt), 32'd0);
`endif

    // All-propagate operand with carry in
    send(16'hFFFF, 16'h0000, 1'b1, 17'h1_0000, 1, 0);
    drain();
`ifdef CBA_BYPASS_STATS_EN
    chk("cnt_ffff", 32'(bypass_cnt), 32'(exp_cnt));
    chk("cnt_ffff_abs", 32'(bypass_cnt), 32'd4);
`endif

    // Back-to-back beats
    send(16'h0001, 16'h0002, 1'b0, 17'h0_0003, 1, 0);
    send(16'h8000, 16'h8000, 1'b0, 17'h1_0000, 1, 0);
    send(16'h1234, 16'h4321, 1'b1, 17'h0_5556, 1, 0);
    drain();

    // Backpressure: fill both stages, hold for 5 cycles
    or_fix = 0;
    send(16'h0F0F, 16'h00F0, 1'b0, 17'h0_0FFF, 0, 0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'({cout_s, sum_s}), 32'h0_0FFF);
    end
`ifdef CBA_BYPASS_STATS_EN
    chk("stall_cnt", 32'(bypass_cnt), 32'(exp_cnt));
`endif
    or_fix = 1;
    drain();

    // Reset with two beats in flight
    or_fix = 0;
    send(16'h0001, 16'h0001, 1'b0, 17'h0_0002, 0, 0);
    send(16'h0002, 16'h0002, 1'b0, 17'h0_0004, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("inrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_sum", 32'({cout_s, sum_s}), 32'd0);
    sb.delete();
    exp_cnt = 0;
`ifdef CBA_BYPASS_STATS_EN
    chk("post_rst_cnt", 32'(bypass_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    or_fix = 1;
    #1;
    chk("post_rel_in_ready", 32'(in_ready), 32'd1);
    send(16'h1111, 16'h2222, 1'b0, 17'h0_3333, 1, 0);
    drain();

    // Statistics clear racing an increment
    send(16'hF0F0, 16'h0F0F, 1'b1, 17'h1_0000, 1, 0);
`ifdef CBA_BYPASS_STATS_EN
    chk("cnt_before_clr", 32'(bypass_cnt), 32'd4);
`endif
    send(16'h000F, 16'h00F0, 1'b0, 17'h0_00FF, 1, 1);
`ifdef CBA_BYPASS_STATS_EN
    chk("cnt_clr", 32'(bypass_cnt), 32'd0);
`endif
    send(16'h00FF, 16'hFF00, 1'b0, 17'h0_FFFF, 1, 0);
`ifdef CBA_BYPASS_STATS_EN
    chk("cnt_after_clr", 32'(bypass_cnt), 32'd4);
`endif
    drain();

    // Random traffic with random backpressure
    or_rand = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra : 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'h0, rc}, 0, 0);
    end
    or_rand = 0;
    or_fix = 1;
    drain();
`ifdef CBA_BYPASS_STATS_EN
    chk("cnt_random", 32'(bypass_cnt), 32'(exp_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
